// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the arbitrated multiplexer.
// Imported by the arbiter and the top level.
package mux_arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Ceiling log2 for flows without $clog2.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_arb_arbiter.sv
// Fixed-priority / round-robin arbiter.
// Owns the last_grant pointer; wraps explicitly at NUM_CH-1.
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ARB_MODE = ARB_RR,
  parameter int CH_W     = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  logic [CH_W-1:0] last_grant;
  logic [CH_W-1:0] sel;
  logic            found;
  int              base;
  int              idx;

  // Fixed priority is a scan that always starts after NUM_CH-1.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    sel       = '0;
    base      = (ARB_MODE == ARB_RR) ? int'(last_grant) : NUM_CH - 1;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = base + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      sel = CH_W'(idx);
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        grant_idx  = sel;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= CH_W'(NUM_CH - 1);
    end else if (advance && ARB_MODE == ARB_RR) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/mux_arb_nw.sv
// N-channel arbitrated multiplexer with valid/ready handshakes
// and a registered output stage.
module mux_arb_nw
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_CH   = 4,
  parameter int ARB_MODE = ARB_RR,
  parameter int CH_W     = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic              load_en;
  logic              xfer;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic [WIDTH-1:0]  sel_data;

  assign load_en  = ~out_valid | out_ready;
  assign in_ready = grant & {NUM_CH{load_en & rst_n}};
  assign xfer     = |(in_valid & in_ready);

  rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE),
    .CH_W     (CH_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // One-hot AND-OR select keeps the mux flat.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_data = sel_data
               | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load_en) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_ch    <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_nw.sv
// Scoreboard bench for mux_arb_nw: RR 4ch, fixed 4ch,
// RR 3ch and a randomised RR 2ch x 8-bit instance.
module tb_mux_arb_nw;
  import mux_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] d;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  logic [7:0] dq0[$];
  logic [7:0] dq1[$];
  logic [1:0] acc;

  logic [127:0] a_data;
  logic [3:0]   a_valid, a_rdy;
  logic [31:0]  a_odata;
  logic [1:0]   a_och;
  logic         a_ov, a_ordy;

  logic [127:0] b_data;
  logic [3:0]   b_valid, b_rdy;
  logic [31:0]  b_odata;
  logic [1:0]   b_och;
  logic         b_ov, b_ordy;

  logic [95:0]  c_data;
  logic [2:0]   c_valid, c_rdy;
  logic [31:0]  c_odata;
  logic [1:0]   c_och;
  logic         c_ov, c_ordy;

  logic [15:0]  d_data;
  logic [1:0]   d_valid, d_rdy;
  logic [7:0]   d_odata;
  logic [0:0]   d_och;
  logic         d_ov, d_ordy;

  mux_arb_nw #(.WIDTH(32), .NUM_CH(4), .ARB_MODE(ARB_RR)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_rdy), .out_data(a_odata), .out_ch(a_och),
    .out_valid(a_ov), .out_ready(a_ordy)
  );

  mux_arb_nw #(.WIDTH(32), .NUM_CH(4), .ARB_MODE(ARB_FIXED)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_rdy), .out_data(b_odata), .out_ch(b_och),
    .out_valid(b_ov), .out_ready(b_ordy)
  );

  mux_arb_nw #(.WIDTH(32), .NUM_CH(3), .ARB_MODE(ARB_RR)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid),
    .in_ready(c_rdy), .out_data(c_odata), .out_ch(c_och),
    .out_valid(c_ov), .out_ready(c_ordy)
  );

  mux_arb_nw #(.WIDTH(8), .NUM_CH(2), .ARB_MODE(ARB_RR)) u_d (
    .clk(clk), .rst_n(rst_n), .in_data(d_data), .in_valid(d_valid),
    .in_ready(d_rdy), .out_data(d_odata), .out_ch(d_och),
    .out_valid(d_ov), .out_ready(d_ordy)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: output word with empty queue at %0t",
             name, $time);
  endtask

  task automatic push(input int which, input int ch,
                      input logic [31:0] d);
    exp_t e;
    e.ch = 2'(ch);
    e.d  = d;
    case (which)
      0: qa.push_back(e);
      1: qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  exp_t ea, eb, ec;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_onehot", 64'($countones(a_rdy) <= 1), 64'd1);
      if (a_ov && a_ordy) begin
        if (qa.size() == 0) fail("a_extra");
        else begin
          ea = qa.pop_front();
          chk("a_ch", 64'(a_och), 64'(ea.ch));
          chk("a_data", 64'(a_odata), 64'(ea.d));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("b_onehot", 64'($countones(b_rdy) <= 1), 64'd1);
      if (b_ov && b_ordy) begin
        if (qb.size() == 0) fail("b_extra");
        else begin
          eb = qb.pop_front();
          chk("b_ch", 64'(b_och), 64'(eb.ch));
          chk("b_data", 64'(b_odata), 64'(eb.d));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("c_onehot", 64'($countones(c_rdy) <= 1), 64'd1);
      if (c_ov && c_ordy) begin
        if (qc.size() == 0) fail("c_extra");
        else begin
          ec = qc.pop_front();
          chk("c_ch", 64'(c_och), 64'(ec.ch));
          chk("c_data", 64'(c_odata), 64'(ec.d));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("d_onehot", 64'($countones(d_rdy) <= 1), 64'd1);
      if (d_ov && d_ordy) begin
        if (d_och == 1'b0) begin
          if (dq0.size() == 0) fail("d_extra0");
          else chk("d_data0", 64'(d_odata), 64'(dq0.pop_front()));
        end else begin
          if (dq1.size() == 0) fail("d_extra1");
          else chk("d_data1", 64'(d_odata), 64'(dq1.pop_front()));
        end
      end
      if (d_valid[0] && d_rdy[0]) begin
        dq0.push_back(d_data[7:0]);
        acc[0] = 1'b1;
      end
      if (d_valid[1] && d_rdy[1]) begin
        dq1.push_back(d_data[15:8]);
        acc[1] = 1'b1;
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    acc     = '0;
    a_data  = '0; a_valid = 4'hF; a_ordy = 1'b0;
    b_data  = '0; b_valid = '0;   b_ordy = 1'b0;
    c_data  = '0; c_valid = '0;   c_ordy = 1'b0;
    d_data  = '0; d_valid = '0;   d_ordy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_ov", 64'(a_ov), 64'd0);
    chk("rst_a_data", 64'(a_odata), 64'd0);
    chk("rst_a_ch", 64'(a_och), 64'd0);
    chk("rst_a_rdy", 64'(a_rdy), 64'd0);
    chk("rst_c_ov", 64'(c_ov), 64'd0);
    chk("rst_d_ov", 64'(d_ov), 64'd0);
    a_valid = '0;
    rst_n   = 1'b1;
    tick();

    // Round-robin rotation with all channels valid.
    a_data  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    a_valid = 4'hF;
    a_ordy  = 1'b1;
    for (int i = 0; i < 5; i++) push(0, i % 4, 32'hA0 + 32'(i % 4));
    tick();
    chk("rr_first_ov", 64'(a_ov), 64'd1);
    repeat (4) tick();
    a_valid = '0;
    repeat (2) tick();
    chk("rr_idle_ov", 64'(a_ov), 64'd0);

    // Backpressure.
    a_data  = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    a_ordy  = 1'b0;
    a_valid = 4'b0001;
    push(0, 0, 32'hC0);
    push(0, 1, 32'hC1);
    push(0, 2, 32'hC2);
    tick();
    a_valid = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rdy", 64'(a_rdy), 64'd0);
      chk("bp_data", 64'(a_odata), 64'hC0);
      chk("bp_ov", 64'(a_ov), 64'd1);
      tick();
    end
    a_ordy = 1'b1;
    #1;
    chk("bp_rel_rdy", 64'(a_rdy), 64'b0010);
    tick();
    a_valid = 4'b0100;
    #1;
    chk("bp_next_rdy", 64'(a_rdy), 64'b0100);
    tick();
    a_valid = '0;
    repeat (2) tick();

    // Drain without refill.
    a_data[127:96] = 32'h1234;
    a_valid = 4'b1000;
    a_ordy  = 1'b0;
    push(0, 3, 32'h1234);
    tick();
    a_valid = '0;
    #1;
    chk("dr_ov_full", 64'(a_ov), 64'd1);
    a_ordy = 1'b1;
    tick();
    chk("dr_ov", 64'(a_ov), 64'd0);
    chk("dr_data", 64'(a_odata), 64'h1234);
    chk("dr_ch", 64'(a_och), 64'd3);

    // Fixed priority.
    b_data  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    b_valid = 4'b1100;
    b_ordy  = 1'b1;
    for (int i = 0; i < 4; i++) push(1, 2, 32'hD2);
    push(1, 3, 32'hD3);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fp_rdy2", 64'(b_rdy), 64'b0100);
      tick();
    end
    b_valid = 4'b1000;
    #1;
    chk("fp_rdy3", 64'(b_rdy), 64'b1000);
    tick();
    b_valid = '0;
    repeat (2) tick();

    // Three channels, then asynchronous reset mid-stream.
    c_data  = {32'hE2, 32'hE1, 32'hE0};
    c_valid = 3'b111;
    c_ordy  = 1'b1;
    push(2, 0, 32'hE0);
    push(2, 1, 32'hE1);
    push(2, 2, 32'hE2);
    repeat (4) tick();
    chk("c3_wrap_ov", 64'(c_ov), 64'd1);
    chk("c3_wrap_ch", 64'(c_och), 64'd0);
    chk("c3_wrap_data", 64'(c_odata), 64'hE0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ov", 64'(c_ov), 64'd0);
    chk("arst_data", 64'(c_odata), 64'd0);
    chk("arst_rdy", 64'(c_rdy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("arst_first_rdy", 64'(c_rdy), 64'b001);
    push(2, 0, 32'hE0);
    tick();
    c_valid = '0;
    repeat (2) tick();

    // Random valid/ready on the 2-channel 8-bit instance.
    for (int n = 0; n < 4000; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (!d_valid[i] || acc[i]) begin
          d_valid[i]        = 1'($urandom_range(0, 1));
          d_data[i*8 +: 8]  = 8'($urandom);
          acc[i]            = 1'b0;
        end
      end
      d_ordy = ($urandom_range(0, 3) != 0);
    end
    tick();
    d_valid = '0;
    d_ordy  = 1'b1;
    repeat (3) tick();

    chk("qa_empty", 64'(qa.size()), 64'd0);
    chk("qb_empty", 64'(qb.size()), 64'd0);
    chk("qc_empty", 64'(qc.size()), 64'd0);
    chk("dq0_empty", 64'(dq0.size()), 64'd0);
    chk("dq1_empty", 64'(dq1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
